// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the fetch/load-store arbiter.
//   arb_state_e : arbiter FSM states (one outstanding transaction at a time)
//   Resp*       : AXI response encodings, passed through unmodified
package axi_lite_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIfuRd = 2'd1,
      StLsuRd = 2'd2,
      StLsuWr = 2'd3
   } arb_state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Arbitrates the IFU read port and the LSU read/write ports onto a single AXI4-Lite master
// feeding the AXI4-Lite-to-AXI4 bridge. One transaction is outstanding at a time.
//   clk, rst        : clock, asynchronous active-high reset
//   ifu_ar*/ifu_r*  : instruction-fetch read channel (upstream master)
//   lsu_aw*/w*/b*   : load-store write channels (upstream master)
//   lsu_ar*/lsu_r*  : load-store read channels (upstream master)
//   out_*           : downstream AXI4-Lite master towards the bridge
// RR_EN = 1 alternates IFU/LSU on a read tie; RR_EN = 0 gives the LSU fixed priority.
// Writes always win over reads in IDLE.
module axi_lite_arbiter
   import axi_lite_pkg::*;
#(
   parameter int unsigned RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   // IFU read
   input  logic [31:0] ifu_araddr,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   // LSU write
   input  logic [31:0] lsu_awaddr,
   input  logic        lsu_awvalid,
   output logic        lsu_awready,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wstrb,
   input  logic        lsu_wvalid,
   output logic        lsu_wready,
   output logic [1:0]  lsu_bresp,
   output logic        lsu_bvalid,
   input  logic        lsu_bready,
   // LSU read
   input  logic [31:0] lsu_araddr,
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_rresp,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   // Downstream master
   output logic [31:0] out_awaddr,
   output logic        out_awvalid,
   input  logic        out_awready,
   output logic [31:0] out_wdata,
   output logic [3:0]  out_wstrb,
   output logic        out_wvalid,
   input  logic        out_wready,
   input  logic [1:0]  out_bresp,
   input  logic        out_bvalid,
   output logic        out_bready,
   output logic [31:0] out_araddr,
   output logic        out_arvalid,
   input  logic        out_arready,
   input  logic [31:0] out_rdata,
   input  logic [1:0]  out_rresp,
   input  logic        out_rvalid,
   output logic        out_rready
);

   arb_state_e state_q, state_d;
   logic       ar_done_q, ar_done_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       last_lsu_q, last_lsu_d;  // 1 = previous read grant went to the LSU

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      ar_done_d  = ar_done_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      last_lsu_d = last_lsu_q;
      unique case (state_q)
         StIdle: begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (lsu_awvalid) begin
               state_d = StLsuWr;
            end else if (ifu_arvalid && lsu_arvalid) begin
               // On a tie, serve whoever lost last time; fixed LSU priority otherwise
               if ((RR_EN != 0) && last_lsu_q) begin
                  state_d    = StIfuRd;
                  last_lsu_d = 1'b0;
               end else begin
                  state_d    = StLsuRd;
                  last_lsu_d = 1'b1;
               end
            end else if (lsu_arvalid) begin
               state_d    = StLsuRd;
               last_lsu_d = 1'b1;
            end else if (ifu_arvalid) begin
               state_d    = StIfuRd;
               last_lsu_d = 1'b0;
            end
         end
         StIfuRd, StLsuRd: begin
            if (out_arvalid && out_arready) ar_done_d = 1'b1;
            if (out_rvalid && out_rready) begin
               state_d   = StIdle;
               ar_done_d = 1'b0;
            end
         end
         StLsuWr: begin
            if (out_awvalid && out_awready) aw_done_d = 1'b1;
            if (out_wvalid && out_wready) w_done_d = 1'b1;
            if (out_bvalid && out_bready) begin
               state_d   = StIdle;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         ar_done_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         last_lsu_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ar_done_q  <= ar_done_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         last_lsu_q <= last_lsu_d;
      end
   end

   // Routing: everything is zero unless the registered state grants that path, so reset
   // (which forces StIdle) zeroes all outputs immediately.
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      ifu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = '0;
      lsu_bvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_rvalid  = 1'b0;
      out_awaddr  = '0;
      out_awvalid = 1'b0;
      out_wdata   = '0;
      out_wstrb   = '0;
      out_wvalid  = 1'b0;
      out_bready  = 1'b0;
      out_araddr  = '0;
      out_arvalid = 1'b0;
      out_rready  = 1'b0;
      unique case (state_q)
         StIfuRd: begin
            out_araddr  = ifu_araddr;
            out_arvalid = ifu_arvalid & ~ar_done_q;
            ifu_arready = out_arready & ~ar_done_q;
            ifu_rdata   = out_rdata;
            ifu_rresp   = out_rresp;
            ifu_rvalid  = out_rvalid;
            out_rready  = ifu_rready;
         end
         StLsuRd: begin
            out_araddr  = lsu_araddr;
            out_arvalid = lsu_arvalid & ~ar_done_q;
            lsu_arready = out_arready & ~ar_done_q;
            lsu_rdata   = out_rdata;
            lsu_rresp   = out_rresp;
            lsu_rvalid  = out_rvalid;
            out_rready  = lsu_rready;
         end
         StLsuWr: begin
            // AW and W complete independently; each valid is masked once its beat is taken
            out_awaddr  = lsu_awaddr;
            out_awvalid = lsu_awvalid & ~aw_done_q;
            lsu_awready = out_awready & ~aw_done_q;
            out_wdata   = lsu_wdata;
            out_wstrb   = lsu_wstrb;
            out_wvalid  = lsu_wvalid & ~w_done_q;
            lsu_wready  = out_wready & ~w_done_q;
            lsu_bresp   = out_bresp;
            lsu_bvalid  = out_bvalid;
            out_bready  = lsu_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter (RR_EN = 1). The bench plays both the
// upstream masters and the downstream slave; inputs change 1 time unit after a rising edge
// and outputs are sampled 2 units later.
module tb_axi_lite_arbiter;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_araddr, lsu_awaddr, lsu_wdata, lsu_araddr, out_rdata;
   logic        ifu_arvalid, ifu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
   logic        lsu_arvalid, lsu_rready, out_awready, out_wready, out_bvalid;
   logic        out_arready, out_rvalid;
   logic [3:0]  lsu_wstrb;
   logic [1:0]  out_bresp, out_rresp;
   logic        ifu_arready, ifu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
   logic        lsu_arready, lsu_rvalid, out_awvalid, out_wvalid, out_bready;
   logic        out_arvalid, out_rready;
   logic [31:0] ifu_rdata, lsu_rdata, out_awaddr, out_wdata, out_araddr;
   logic [1:0]  ifu_rresp, lsu_bresp, lsu_rresp;
   logic [3:0]  out_wstrb;
   logic [181:0] all_outs;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign all_outs = {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                      lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                      lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                      out_awaddr, out_awvalid, out_wdata, out_wstrb, out_wvalid, out_bready,
                      out_araddr, out_arvalid, out_rready};

   axi_lite_arbiter #(.RR_EN(1)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
      .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
      .lsu_bready(lsu_bready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
      .lsu_rready(lsu_rready),
      .out_awaddr(out_awaddr), .out_awvalid(out_awvalid), .out_awready(out_awready),
      .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wvalid(out_wvalid),
      .out_wready(out_wready), .out_bresp(out_bresp), .out_bvalid(out_bvalid),
      .out_bready(out_bready),
      .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
      .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rvalid(out_rvalid),
      .out_rready(out_rready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
      lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
      lsu_bready = 0; lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
      out_awready = 0; out_wready = 0; out_bresp = '0; out_bvalid = 0;
      out_arready = 0; out_rdata = '0; out_rresp = '0; out_rvalid = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      // Busy inputs during reset must not leak through or start a grant
      ifu_arvalid = 1; lsu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1;
      out_rvalid = 1; out_rdata = 32'hDEAD_BEEF; out_bvalid = 1; out_bresp = RespDecerr;
      out_arready = 1; out_awready = 1; out_wready = 1;
      tick(); tick(); #2;
      n_vec++; if (all_outs !== '0) begin n_err++;
         $display("FAIL reset_outs: got %h, expected 0", all_outs); end
      n_vec++; if (dut.state_q !== StIdle) begin n_err++;
         $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, StIdle); end
      clear_inputs();
      tick();
      rst = 0;
      #2;
      n_vec++; if (all_outs !== '0) begin n_err++;
         $display("FAIL idle_outs: got %h, expected 0", all_outs); end
   endtask

   task automatic test_ifu_read();
      ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; out_arready = 1;
      #2;
      n_vec++; if (out_arvalid !== 1'b0) begin n_err++;
         $display("FAIL ifu_arb_latency: got %b, expected 0", out_arvalid); end
      tick(); #2;
      n_vec++; if ({out_arvalid, ifu_arready, out_araddr} !== {2'b11, 32'h3000_0000}) begin
         n_err++; $display("FAIL ifu_ar_issue: got %b%b %h, expected 11 30000000",
                           out_arvalid, ifu_arready, out_araddr); end
      tick(); #2;  // AR handshake taken; arvalid still high but must not be reissued
      n_vec++; if ({out_arvalid, ifu_arready} !== 2'b00) begin n_err++;
         $display("FAIL ifu_ar_noreissue: got %b%b, expected 00", out_arvalid, ifu_arready);
      end
      n_vec++; if (lsu_rvalid !== 1'b0) begin n_err++;
         $display("FAIL ifu_lsu_rvalid_wait: got %b, expected 0", lsu_rvalid); end
      tick();
      ifu_arvalid = 0; out_rvalid = 1; out_rdata = 32'hDEAD_BEEF; out_rresp = RespOkay;
      ifu_rready = 1;
      #2;
      n_vec++; if ({ifu_rvalid, ifu_rdata, ifu_rresp} !== {1'b1, 32'hDEAD_BEEF, RespOkay})
      begin n_err++; $display("FAIL ifu_r_data: got %b %h %0d, expected 1 deadbeef 0",
                              ifu_rvalid, ifu_rdata, ifu_rresp); end
      n_vec++; if ({lsu_rvalid, out_rready} !== 2'b01) begin n_err++;
         $display("FAIL ifu_r_route: got %b%b, expected 01", lsu_rvalid, out_rready); end
      tick();
      out_rvalid = 0; ifu_rready = 0; out_arready = 0;
      #2;
      n_vec++; if (dut.state_q !== StIdle) begin n_err++;
         $display("FAIL ifu_back_idle: got %0d, expected %0d", dut.state_q, StIdle); end
   endtask

   task automatic test_round_robin();
      bit [2:0]    exp_lsu = 3'b101;  // rounds 0..2: LSU, IFU, LSU
      arb_state_e  exp_st;
      logic [31:0] exp_addr;
      for (int i = 0; i < 3; i++) begin
         ifu_arvalid = 1; lsu_arvalid = 1; out_arready = 1;
         ifu_araddr = 32'h1000_0000 + i; lsu_araddr = 32'h2000_0000 + i;
         tick(); #2;
         exp_st   = exp_lsu[i] ? StLsuRd : StIfuRd;
         exp_addr = exp_lsu[i] ? 32'h2000_0000 + i : 32'h1000_0000 + i;
         n_vec++; if (dut.state_q !== exp_st) begin n_err++;
            $display("FAIL rr_grant_%0d: got %0d, expected %0d", i, dut.state_q, exp_st); end
         n_vec++; if (out_araddr !== exp_addr) begin n_err++;
            $display("FAIL rr_addr_%0d: got %h, expected %h", i, out_araddr, exp_addr); end
         tick();
         if (exp_lsu[i]) lsu_arvalid = 0;
         else ifu_arvalid = 0;
         out_arready = 0; out_rvalid = 1; out_rdata = 32'hA000_0000 + i;
         ifu_rready = 1; lsu_rready = 1;
         #2;
         n_vec++; if ({lsu_rvalid, ifu_rvalid} !== {exp_lsu[i], ~exp_lsu[i]}) begin n_err++;
            $display("FAIL rr_rvalid_%0d: got %b%b, expected %b%b", i, lsu_rvalid, ifu_rvalid,
                     exp_lsu[i], ~exp_lsu[i]); end
         tick();
         out_rvalid = 0;
         #2;
         n_vec++; if (dut.state_q !== StIdle) begin n_err++;
            $display("FAIL rr_idle_%0d: got %0d, expected %0d", i, dut.state_q, StIdle); end
      end
      ifu_arvalid = 0; lsu_arvalid = 0; ifu_rready = 0; lsu_rready = 0;
   endtask

   task automatic test_write_w_first();
      lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010; lsu_wvalid = 1;
      lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF; out_awready = 0; out_wready = 1;
      tick(); #2;
      n_vec++; if ({out_wvalid, lsu_wready, out_wdata, out_wstrb} !==
                   {2'b11, 32'h1234_5678, 4'hF}) begin n_err++;
         $display("FAIL wr_w_issue: got %b%b %h %h, expected 11 12345678 f",
                  out_wvalid, lsu_wready, out_wdata, out_wstrb); end
      n_vec++; if ({out_awvalid, lsu_awready, out_awaddr} !== {2'b10, 32'h8000_0010}) begin
         n_err++; $display("FAIL wr_aw_issue: got %b%b %h, expected 10 80000010",
                           out_awvalid, lsu_awready, out_awaddr); end
      for (int k = 0; k < 2; k++) begin
         tick(); #2;  // W taken; wvalid from the LSU held high must stay masked
         n_vec++; if ({out_wvalid, lsu_wready, out_awvalid} !== 3'b001) begin n_err++;
            $display("FAIL wr_w_noreissue_%0d: got %b%b%b, expected 001",
                     k, out_wvalid, lsu_wready, out_awvalid); end
      end
      tick();
      out_awready = 1;
      #2;
      n_vec++; if (lsu_awready !== 1'b1) begin n_err++;
         $display("FAIL wr_aw_ready: got %b, expected 1", lsu_awready); end
      tick();
      lsu_awvalid = 0; lsu_wvalid = 0; out_awready = 0; out_wready = 0;
      out_bvalid = 1; out_bresp = RespOkay; lsu_bready = 1;
      #2;
      n_vec++; if ({lsu_bvalid, lsu_bresp, out_bready, out_awvalid} !== {1'b1, RespOkay, 2'b10})
      begin n_err++; $display("FAIL wr_b_route: got %b %0d %b %b, expected 1 0 1 0",
                              lsu_bvalid, lsu_bresp, out_bready, out_awvalid); end
      tick();
      out_bvalid = 0; lsu_bready = 0;
      #2;
      n_vec++; if (dut.state_q !== StIdle) begin n_err++;
         $display("FAIL wr_back_idle: got %0d, expected %0d", dut.state_q, StIdle); end
   endtask

   task automatic test_write_before_read();
      lsu_awvalid = 1; lsu_awaddr = 32'h8000_0020; lsu_wvalid = 1; lsu_wdata = 32'h0BAD_F00D;
      lsu_wstrb = 4'h3; ifu_arvalid = 1; ifu_araddr = 32'h3000_0040;
      out_awready = 1; out_wready = 1; out_arready = 1;
      tick(); #2;
      n_vec++; if (dut.state_q !== StLsuWr) begin n_err++;
         $display("FAIL wvr_grant: got %0d, expected %0d", dut.state_q, StLsuWr); end
      n_vec++; if ({out_arvalid, ifu_arready} !== 2'b00) begin n_err++;
         $display("FAIL wvr_ifu_blocked: got %b%b, expected 00", out_arvalid, ifu_arready); end
      tick();
      lsu_awvalid = 0; lsu_wvalid = 0; out_bvalid = 1; out_bresp = RespOkay; lsu_bready = 1;
      tick();  // B handshake edge
      out_bvalid = 0; lsu_bready = 0;
      #2;
      n_vec++; if ({dut.state_q, out_arvalid} !== {StIdle, 1'b0}) begin n_err++;
         $display("FAIL wvr_idle_gap: got %0d %b, expected %0d 0",
                  dut.state_q, out_arvalid, StIdle); end
      tick(); #2;
      n_vec++; if ({dut.state_q, out_arvalid, out_araddr} !== {StIfuRd, 1'b1, 32'h3000_0040})
      begin n_err++; $display("FAIL wvr_ifu_start: got %0d %b %h, expected %0d 1 30000040",
                              dut.state_q, out_arvalid, out_araddr, StIfuRd); end
      tick();
      ifu_arvalid = 0; out_arready = 0; out_rvalid = 1; out_rdata = 32'h0; ifu_rready = 1;
      tick();
      out_rvalid = 0; ifu_rready = 0;
   endtask

   task automatic test_slverr_stall();
      lsu_arvalid = 1; lsu_araddr = 32'h4000_0000; out_arready = 1;
      tick(); tick();
      lsu_arvalid = 0; out_arready = 0; out_rvalid = 1; out_rresp = RespSlverr;
      out_rdata = 32'hBAD0_0001; lsu_rready = 0;
      for (int k = 0; k < 4; k++) begin
         #2;
         n_vec++; if ({dut.state_q, lsu_rvalid, lsu_rresp, lsu_rdata} !==
                      {StLsuRd, 1'b1, RespSlverr, 32'hBAD0_0001}) begin n_err++;
            $display("FAIL slverr_hold_%0d: got %0d %b %0d %h, expected %0d 1 2 bad00001",
                     k, dut.state_q, lsu_rvalid, lsu_rresp, lsu_rdata, StLsuRd); end
         tick();
      end
      lsu_rready = 1;
      #2;
      n_vec++; if (out_rready !== 1'b1) begin n_err++;
         $display("FAIL slverr_rready: got %b, expected 1", out_rready); end
      tick();
      out_rvalid = 0; lsu_rready = 0; out_rresp = RespOkay;
      #2;
      n_vec++; if (dut.state_q !== StIdle) begin n_err++;
         $display("FAIL slverr_idle: got %0d, expected %0d", dut.state_q, StIdle); end
   endtask

   task automatic test_reset_mid_read();
      lsu_arvalid = 1; lsu_araddr = 32'h4000_0100; out_arready = 1;
      tick(); tick();
      lsu_arvalid = 0; out_arready = 0; out_rvalid = 1; out_rdata = 32'h5555_AAAA;
      out_rresp = RespDecerr; lsu_rready = 0;
      #2;
      n_vec++; if ({lsu_rvalid, lsu_rresp} !== {1'b1, RespDecerr}) begin n_err++;
         $display("FAIL rstmid_pre: got %b %0d, expected 1 3", lsu_rvalid, lsu_rresp); end
      rst = 1;  // mid-cycle, away from any clock edge
      #1;
      n_vec++; if (all_outs !== '0) begin n_err++;
         $display("FAIL rstmid_async_outs: got %h, expected 0", all_outs); end
      n_vec++; if (dut.state_q !== StIdle) begin n_err++;
         $display("FAIL rstmid_async_state: got %0d, expected %0d", dut.state_q, StIdle); end
      tick(); tick();
      rst = 0;  // late response still presented downstream
      #2;
      n_vec++; if ({lsu_rvalid, ifu_rvalid, out_rready} !== 3'b000) begin n_err++;
         $display("FAIL rstmid_late_r: got %b%b%b, expected 000",
                  lsu_rvalid, ifu_rvalid, out_rready); end
      tick(); #2;
      n_vec++; if ({dut.state_q, all_outs} !== {StIdle, 182'd0}) begin n_err++;
         $display("FAIL rstmid_idle: got %0d %h, expected %0d 0",
                  dut.state_q, all_outs, StIdle); end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_write_w_first();
      test_write_before_read();
      test_slverr_stall();
      test_reset_mid_read();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
